// File: rtl/bcd_converter.sv
// Purpose : binary-to-BCD converter (sequential double-dabble) with per-digit one-hot decode and leading-zero blanking.
// Latency : result valid exactly WIDTH clk edges after the accepting edge.
// Backpressure: single-entry; in_ready only while idle, result held in DONE until out_ready.
// Ports   : clk/rst_n (async active-low), in_valid/in_ready/bin_in (input handshake),
//           out_valid/out_ready (result handshake), bcd_out (digit 0 in [3:0]),
//           onehot_out (bit 10*i+d for digit i == d), blank_out (leading-zero flags).
module bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [10*DIGITS-1:0]  onehot_out,
  output logic [DIGITS-1:0]     blank_out
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  // The digit count must cover the largest binary value, otherwise the
  // top digit would overflow during the final shift.
  generate
    if (WIDTH < 4 || WIDTH > 20 || pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_cfg_bad
      $error("bcd_converter: WIDTH must be 4..20 and 10**DIGITS must exceed 2**WIDTH-1");
    end
  endgenerate

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS + WIDTH;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   scr_q, scr_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [4*DIGITS-1:0]   adj;
  logic [SW-1:0]         sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;

    // Double-dabble correction: any digit >= 5 would become >= 10 after
    // the doubling shift, so pre-add 3 to carry it into the next digit.
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    sh = {adj, bin_q} << 1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = sh[SW-1:WIDTH];
        bin_d = sh[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        // Last step: publish the finished scratch on the same edge.
        if (cnt_q == CW'(1)) begin
          bcd_d   = sh[SW-1:WIDTH];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_q;

  // Decode depends only on the registered result, never on inputs.
  logic zero_run;
  always_comb begin
    zero_run   = 1'b1;
    blank_out  = '0;
    onehot_out = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (bcd_q[4*i +: 4] == 4'd0);
      blank_out[i] = (i > 0) && zero_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (!blank_out[i]) onehot_out[10*i + int'(bcd_q[4*i +: 4])] = 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
module tb_bcd_converter;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     bin_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  bcd_out;
  logic [10*DIGITS-1:0] onehot_out;
  logic [DIGITS-1:0]    blank_out;

  int checks = 0;
  int errors = 0;

  bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bin_in     (bin_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bcd_out    (bcd_out),
    .onehot_out (onehot_out),
    .blank_out  (blank_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic int p10(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] blank_of(input int v);
    logic [DIGITS-1:0] b;
    b = '0;
    for (int i = 1; i < DIGITS; i++) b[i] = (v < p10(i));
    return b;
  endfunction

  function automatic logic [10*DIGITS-1:0] onehot_of(input int v);
    logic [10*DIGITS-1:0] o;
    o = '0;
    for (int i = 0; i < DIGITS; i++)
      if (i == 0 || v >= p10(i)) o[10*i + (v / p10(i)) % 10] = 1'b1;
    return o;
  endfunction

  // Transaction-level model: edges remaining until result, result held flag.
  int m_pending = 0;
  bit m_holding = 0;
  int m_val     = 0;
  int m_last    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 0;
      m_holding = 0;
      m_last    = 0;
    end else if (m_holding) begin
      if (out_ready) m_holding = 0;
    end else if (m_pending > 0) begin
      m_pending = m_pending - 1;
      if (m_pending == 0) begin
        m_holding = 1;
        m_last    = m_val;
      end
    end else if (in_valid) begin
      m_val     = int'(bin_in);
      m_pending = WIDTH;
    end
  end

  always @(negedge clk) begin
    chk("cmp_in_ready",  in_ready,   (!m_holding && m_pending == 0));
    chk("cmp_out_valid", out_valid,  m_holding);
    chk("cmp_bcd_out",   bcd_out,    to_bcd(m_last));
    chk("cmp_onehot",    onehot_out, onehot_of(m_last));
    chk("cmp_blank",     blank_out,  blank_of(m_last));
  end

  // ---------------- directed stimulus ----------------
  // Called at posedge+1 with the converter idle.
  task automatic conv(input int val, input int hold, input logic [11:0] eb,
                      input logic [29:0] eo, input logic [2:0] ebl);
    int edges;
    in_valid = 1'b1;
    bin_in   = WIDTH'(val);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in   = 8'hA5;
    edges    = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, 8);
    chk("lit_bcd", bcd_out, eb);
    chk("lit_onehot", onehot_out, eo);
    chk("lit_blank", blank_out, ebl);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_bcd", bcd_out, eb);
      chk("hold_blank", blank_out, ebl);
      chk("hold_in_ready", in_ready, 0);
    end
    chk("pre_release_in_ready", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
  endtask

  initial begin
    int edges;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bin_in    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bcd", bcd_out, 12'h000);
    chk("rst_onehot", onehot_out, 30'd1);
    chk("rst_blank", blank_out, 3'b110);
    rst_n = 1'b1;
    @(posedge clk); #1;

    conv(0,   0, 12'h000, 30'd1, 3'b110);
    conv(255, 0, 12'h255, (30'd1 << 5) | (30'd1 << 15) | (30'd1 << 22), 3'b000);
    conv(209, 0, 12'h209, (30'd1 << 9) | (30'd1 << 10) | (30'd1 << 22), 3'b000);
    conv(7,   5, 12'h007, (30'd1 << 7), 3'b110);
    conv(10,  1, 12'h010, (30'd1 << 0) | (30'd1 << 11), 3'b100);
    conv(99,  0, 12'h099, (30'd1 << 9) | (30'd1 << 19), 3'b100);
    conv(100, 2, 12'h100, (30'd1 << 0) | (30'd1 << 10) | (30'd1 << 21), 3'b000);

    // New input every cycle while busy: only the first is converted, and
    // nothing is taken on the DONE-to-IDLE edge.
    in_valid = 1'b1;
    bin_in   = 8'd123;
    @(posedge clk); #1;
    edges = 0;
    while (!out_valid && edges < 40) begin
      bin_in = WIDTH'(edges * 37 + 11);
      @(posedge clk); #1;
      edges++;
    end
    chk("flood_latency", edges, 8);
    chk("flood_bcd", bcd_out, 12'h123);
    chk("flood_onehot", onehot_out, (30'd1 << 3) | (30'd1 << 12) | (30'd1 << 21));
    bin_in    = 8'd77;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("flood_no_accept_in_ready", in_ready, 1);
    chk("flood_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset during step 4 of 200 abandons it.
    in_valid = 1'b1;
    bin_in   = 8'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_bcd", bcd_out, 12'h000);
    chk("midrst_onehot", onehot_out, 30'd1);
    chk("midrst_blank", blank_out, 3'b110);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_result", out_valid, 0);
    conv(13, 0, 12'h013, (30'd1 << 3) | (30'd1 << 11), 3'b100);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
